// File: rtl/ysyx_23060332_ifu_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decoder handoff
// and pipeline redirects. The master side is the IFU.
interface ysyx_23060332_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [31:0] inst_addr;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        flush;
  logic [31:0] flush_addr;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_o, inst_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    input  jump_en, jump_addr, flush, flush_addr
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_o, inst_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    output jump_en, jump_addr, flush, flush_addr
  );
endinterface

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: one outstanding imem request, single-entry
// instruction buffer toward decode, jump and flush redirects.
module ysyx_23060332_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic                  clk,
  input logic                  rst,
  ysyx_23060332_ifu_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] BOOT_PC = RESET_PC & 32'hFFFF_FFFC;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] redir_pc;
  logic        drop;
  logic [31:0] inst_q;
  logic [31:0] inst_addr_q;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ:  if (bus.imem_req_ready) state_nxt = WAIT;
      WAIT: if (bus.imem_resp_valid)
              state_nxt = (drop || bus.flush) ? REQ : HOLD;
      HOLD: if (bus.flush || bus.inst_ready) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // pc stays on the issued address while a request is in flight, so a flush
  // there parks its target in redir_pc until the stale response is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= BOOT_PC;
      redir_pc    <= BOOT_PC;
      drop        <= 1'b0;
      inst_q      <= NOP;
      inst_addr_q <= BOOT_PC;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (bus.flush)
            pc <= word_align(bus.flush_addr);
          else if (state == HOLD && bus.inst_ready)
            pc <= bus.jump_en ? word_align(bus.jump_addr) : pc + 32'd4;
        end
        REQ: begin
          if (bus.flush) begin
            drop     <= 1'b1;
            redir_pc <= word_align(bus.flush_addr);
          end
        end
        WAIT: begin
          if (bus.imem_resp_valid) begin
            if (bus.flush) begin
              pc   <= word_align(bus.flush_addr);
              drop <= 1'b0;
            end else if (drop) begin
              pc   <= redir_pc;
              drop <= 1'b0;
            end else begin
              inst_q      <= bus.imem_resp_data;
              inst_addr_q <= pc;
            end
          end else if (bus.flush) begin
            drop     <= 1'b1;
            redir_pc <= word_align(bus.flush_addr);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.imem_req_valid = (state == REQ);
    bus.imem_req_addr  = (state == REQ) ? pc : '0;
    bus.inst_valid     = (state == HOLD);
    bus.inst_o         = inst_q;
    bus.inst_addr      = inst_addr_q;
  end

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Bench for ysyx_23060332_ifu: directed fetch/redirect scenarios, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_ysyx_23060332_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ysyx_23060332_ifu_if bus ();

  ysyx_23060332_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] al(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // memory responder knobs
  int unsigned ready_pct;
  int unsigned lat_min;
  int unsigned lat_max;
  bit          stray_en;
  bit          inj_resp;
  bit          fix_data_en;
  logic [31:0] fix_data;

  initial begin
    bit          pend;
    bit          acc_prev;
    bit          real_prev;
    int unsigned cnt;
    pend = 1'b0; acc_prev = 1'b0; real_prev = 1'b0; cnt = 0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    forever begin
      @(posedge clk);
      if (rst) pend = 1'b0;
      else if (acc_prev) begin
        pend = 1'b1;
        cnt  = $urandom_range(lat_max, lat_min) - 1;
      end else if (real_prev) pend = 1'b0;
      else if (pend && cnt != 0) cnt--;
      #2;
      real_prev           = pend && cnt == 0;
      bus.imem_resp_valid = real_prev || inj_resp ||
                            (stray_en && !pend && $urandom_range(7, 0) == 0);
      bus.imem_resp_data  = fix_data_en ? fix_data : $urandom;
      bus.imem_req_ready  = $urandom_range(99, 0) < ready_pct;
      acc_prev            = bus.imem_req_valid && bus.imem_req_ready;
    end
  end

  // Transaction-level model: m_boot = quiet cycle after reset, m_req = request
  // on the bus, m_out = request accepted awaiting data, m_hold = instruction
  // offered to decode, m_drop = in-flight fetch is stale.
  bit          m_boot, m_req, m_out, m_hold, m_drop;
  logic [31:0] m_addr, m_fetch, m_redir, m_inst, m_iaddr;

  initial begin
    bit          have_model;
    bit          stab;
    logic [31:0] stab_addr;
    have_model = 1'b0; stab = 1'b0; stab_addr = '0;
    m_boot = 1'b1; m_req = 1'b0; m_out = 1'b0; m_hold = 1'b0; m_drop = 1'b0;
    m_addr = '0; m_fetch = '0; m_redir = '0; m_inst = NOP; m_iaddr = RESET_PC;
    forever begin
      @(negedge clk);
      if (have_model) begin
        chk1("req_valid", bus.imem_req_valid, m_req);
        if (m_req) chk32("req_addr", bus.imem_req_addr, m_addr);
        chk1("inst_valid", bus.inst_valid, m_hold);
        chk32("inst_o", bus.inst_o, m_inst);
        chk32("inst_addr", bus.inst_addr, m_iaddr);
        if (stab) begin
          chk1("req_stable_valid", bus.imem_req_valid, 1'b1);
          chk32("req_stable_addr", bus.imem_req_addr, stab_addr);
        end
      end
      stab      = bus.imem_req_valid && !bus.imem_req_ready && !rst;
      stab_addr = bus.imem_req_addr;

      if (rst) begin
        m_boot = 1'b1; m_req = 1'b0; m_out = 1'b0; m_hold = 1'b0; m_drop = 1'b0;
        m_inst = NOP; m_iaddr = RESET_PC;
        have_model = 1'b1;
      end else if (m_boot) begin
        m_boot = 1'b0;
        m_req  = 1'b1;
        m_addr = bus.flush ? al(bus.flush_addr) : RESET_PC;
      end else if (m_req) begin
        if (bus.flush) begin
          m_drop  = 1'b1;
          m_redir = al(bus.flush_addr);
        end
        if (bus.imem_req_ready) begin
          m_req   = 1'b0;
          m_out   = 1'b1;
          m_fetch = m_addr;
        end
      end else if (m_out) begin
        if (bus.imem_resp_valid) begin
          m_out = 1'b0;
          if (bus.flush) begin
            m_req = 1'b1; m_addr = al(bus.flush_addr); m_drop = 1'b0;
          end else if (m_drop) begin
            m_req = 1'b1; m_addr = m_redir; m_drop = 1'b0;
          end else begin
            m_hold = 1'b1; m_inst = bus.imem_resp_data; m_iaddr = m_fetch;
          end
        end else if (bus.flush) begin
          m_drop  = 1'b1;
          m_redir = al(bus.flush_addr);
        end
      end else if (m_hold) begin
        if (bus.flush) begin
          m_hold = 1'b0; m_req = 1'b1; m_addr = al(bus.flush_addr);
        end else if (bus.inst_ready) begin
          m_hold = 1'b0; m_req = 1'b1;
          m_addr = bus.jump_en ? al(bus.jump_addr) : m_iaddr + 32'd4;
        end
      end
    end
  end

  initial begin
    total = 0; bad = 0;
    ready_pct = 100; lat_min = 1; lat_max = 1;
    stray_en = 1'b0; inj_resp = 1'b0; fix_data_en = 1'b1; fix_data = 32'h0000_0413;
    rst = 1'b1;
    bus.inst_ready = 1'b0; bus.jump_en = 1'b0; bus.jump_addr = '0;
    bus.flush = 1'b0; bus.flush_addr = '0;

    repeat (3) tick();
    chk1 ("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk1 ("rst_inst_valid", bus.inst_valid, 1'b0);
    chk32("rst_inst_o", bus.inst_o, NOP);
    chk32("rst_inst_addr", bus.inst_addr, RESET_PC);

    // first fetch: quiet cycle, request, wait, hold
    rst = 1'b0;
    chk1 ("boot_idle_quiet", bus.imem_req_valid, 1'b0);
    tick();
    chk1 ("boot_req_valid", bus.imem_req_valid, 1'b1);
    chk32("boot_req_addr", bus.imem_req_addr, 32'h8000_0000);
    tick();
    chk1 ("boot_wait_no_inst", bus.inst_valid, 1'b0);
    tick();
    chk1 ("boot_inst_valid", bus.inst_valid, 1'b1);
    chk32("boot_inst_o", bus.inst_o, 32'h0000_0413);
    chk32("boot_inst_addr", bus.inst_addr, 32'h8000_0000);

    // decoder stall keeps the buffer and suppresses new requests
    ready_pct = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1 ("stall_inst_valid", bus.inst_valid, 1'b1);
      chk32("stall_inst_o", bus.inst_o, 32'h0000_0413);
      chk32("stall_inst_addr", bus.inst_addr, 32'h8000_0000);
      chk1 ("stall_no_req", bus.imem_req_valid, 1'b0);
    end
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk1 ("seq_req_valid", bus.imem_req_valid, 1'b1);
    chk32("seq_req_addr", bus.imem_req_addr, 32'h8000_0004);

    // flush while the request is stalled: request holds, its data is dropped
    bus.flush = 1'b1; bus.flush_addr = 32'h8000_0200;
    tick();
    bus.flush = 1'b0;
    chk32("flush_stall_addr1", bus.imem_req_addr, 32'h8000_0004);
    tick();
    chk32("flush_stall_addr2", bus.imem_req_addr, 32'h8000_0004);
    ready_pct = 100;
    tick();
    chk1 ("flush_stall_valid3", bus.imem_req_valid, 1'b1);
    chk32("flush_stall_addr3", bus.imem_req_addr, 32'h8000_0004);
    tick();
    chk1 ("flush_wait_no_inst", bus.inst_valid, 1'b0);
    tick();
    chk1 ("flush_dropped", bus.inst_valid, 1'b0);
    chk1 ("flush_req_valid", bus.imem_req_valid, 1'b1);
    chk32("flush_req_addr", bus.imem_req_addr, 32'h8000_0200);
    fix_data = 32'h0000_0093;
    tick();
    tick();
    chk32("flush_inst_addr", bus.inst_addr, 32'h8000_0200);
    chk32("flush_inst_o", bus.inst_o, 32'h0000_0093);

    // jump on consume, misaligned target cleared
    bus.inst_ready = 1'b1; bus.jump_en = 1'b1; bus.jump_addr = 32'h8000_0102;
    tick();
    bus.inst_ready = 1'b0; bus.jump_en = 1'b0;
    chk32("jump_req_addr", bus.imem_req_addr, 32'h8000_0100);
    tick();
    tick();
    chk32("jump_inst_addr", bus.inst_addr, 32'h8000_0100);

    // pc+4 wraps at the top of the address space
    bus.inst_ready = 1'b1; bus.jump_en = 1'b1; bus.jump_addr = 32'hFFFF_FFFE;
    tick();
    bus.inst_ready = 1'b0; bus.jump_en = 1'b0;
    chk32("top_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    chk32("top_inst_addr", bus.inst_addr, 32'hFFFF_FFFC);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk1 ("wrap_req_valid", bus.imem_req_valid, 1'b1);
    chk32("wrap_req_addr", bus.imem_req_addr, 32'h0000_0000);

    // reset during WAIT, then a stale response right after release
    lat_min = 20; lat_max = 20;
    tick();
    chk1 ("rstwait_in_flight", bus.imem_req_valid, 1'b0);
    rst = 1'b1; inj_resp = 1'b1;
    tick();
    rst = 1'b0;
    chk1 ("rstwait_quiet", bus.imem_req_valid, 1'b0);
    chk1 ("rstwait_no_inst", bus.inst_valid, 1'b0);
    chk32("rstwait_inst_o", bus.inst_o, NOP);
    chk32("rstwait_inst_addr", bus.inst_addr, RESET_PC);
    lat_min = 1; lat_max = 1;
    tick();
    inj_resp = 1'b0;
    chk1 ("rstwait_req_valid", bus.imem_req_valid, 1'b1);
    chk32("rstwait_req_addr", bus.imem_req_addr, RESET_PC);
    chk1 ("rstwait_stale_ignored", bus.inst_valid, 1'b0);
    tick();
    chk1 ("rstwait_wait", bus.inst_valid, 1'b0);
    tick();
    chk1 ("rstwait_hold", bus.inst_valid, 1'b1);
    chk32("rstwait_hold_addr", bus.inst_addr, RESET_PC);

    // randomized traffic, checked by the model every cycle
    fix_data_en = 1'b0; stray_en = 1'b1;
    ready_pct = 60; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 4000; i++) begin
      bus.inst_ready = $urandom_range(1, 0) == 1;
      bus.jump_en    = $urandom_range(3, 0) == 0;
      bus.jump_addr  = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFC : $urandom;
      bus.flush      = $urandom_range(19, 0) == 0;
      bus.flush_addr = $urandom;
      rst            = $urandom_range(199, 0) == 0;
      tick();
    end
    rst = 1'b0; bus.flush = 1'b0; bus.inst_ready = 1'b0; bus.jump_en = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
